// File: rtl/hvac_plant_scheduler_if.sv
// Zone-request / plant-drive bundle between thermostats and plant scheduler.
// slave: scheduler side (requests in, drives out); master: thermostat/plant side.
interface hvac_plant_scheduler_if #(
  parameter int NZ = 4
);
  logic [NZ-1:0] heat_req;
  logic [NZ-1:0] cool_req;
  logic          heating;
  logic          cooling;
  logic [NZ-1:0] zone_grant;
  logic          conflict;
  logic          busy;

  modport slave (
    input  heat_req, cool_req,
    output heating, cooling, zone_grant, conflict, busy
  );

  modport master (
    output heat_req, cool_req,
    input  heating, cooling, zone_grant, conflict, busy
  );
endinterface

// File: rtl/hvac_plant_scheduler.sv
// Round-robin plant sharing across NZ zones with min-run and dead-time guards.
// Ports: clk, rst_n (async low), bus (slave): heat_req/cool_req in; heating,
// cooling, zone_grant, conflict, busy out (all registered).
// Option: HVAC_PREEMPT_EN releases a run after MAX_RUN cycles if others wait.
module hvac_plant_scheduler #(
  parameter int NZ      = 4,
  parameter int MIN_RUN = 8,
  parameter int DEAD    = 4,
  parameter int MAX_RUN = 32
) (
  input  logic clk,
  input  logic rst_n,
  hvac_plant_scheduler_if.slave bus
);
  localparam int M1   = (MIN_RUN > DEAD) ? MIN_RUN : DEAD;
  localparam int CMAX = (M1 > MAX_RUN) ? M1 : MAX_RUN;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int PW   = $clog2(NZ);

  typedef enum logic [1:0] {
    S_IDLE, S_HEAT, S_COOL, S_DEAD
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [NZ-1:0] grant_q, grant_d;
  logic          heat_q, heat_d;
  logic          cool_q, cool_d;
  logic          conf_q, conf_d;
  logic          busy_q, busy_d;

  logic [NZ-1:0] elig;
  logic [PW-1:0] pick;
  logic          found;
  logic          gh, gc;
  logic          others;
  logic          rel;

  always_comb begin
    elig  = bus.heat_req ^ bus.cool_req;
    found = 1'b0;
    pick  = '0;
    // first eligible zone strictly after the pointer, wrapping
    for (int i = 1; i <= NZ; i++) begin
      if (!found && elig[(int'(ptr_q) + i) % NZ]) begin
        found = 1'b1;
        pick  = PW'((int'(ptr_q) + i) % NZ);
      end
    end
  end

  // while running, the pointer holds the granted zone
  assign gh      = bus.heat_req[ptr_q];
  assign gc      = bus.cool_req[ptr_q];
  assign others  = |(elig & ~(NZ'(1) << ptr_q));
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_inc;
    rel     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = cnt_q;
        if (found) begin
          ptr_d   = pick;
          cnt_d   = CW'(1);
          state_d = bus.heat_req[pick] ? S_HEAT : S_COOL;
        end
      end
      S_HEAT, S_COOL: begin
        if (cnt_q >= CW'(MIN_RUN)) begin
          if (state_q == S_HEAT) rel = !(gh && !gc);
          else                   rel = !(gc && !gh);
        end
`ifdef HVAC_PREEMPT_EN
        if (cnt_q >= CW'(MAX_RUN) && others) rel = 1'b1;
`endif
        if (rel) begin
          state_d = S_DEAD;
          cnt_d   = CW'(1);
        end
      end
      S_DEAD: begin
        if (cnt_q >= CW'(DEAD)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    heat_d  = (state_d == S_HEAT);
    cool_d  = (state_d == S_COOL);
    grant_d = (heat_d || cool_d) ? (NZ'(1) << ptr_d) : '0;
    busy_d  = (state_d != S_IDLE);
    conf_d  = (state_q == S_IDLE) && |(bus.heat_req & bus.cool_req);
  end

`ifndef HVAC_PREEMPT_EN
  logic unused_others;
  assign unused_others = others;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= PW'(NZ - 1);
      cnt_q   <= '0;
      grant_q <= '0;
      heat_q  <= 1'b0;
      cool_q  <= 1'b0;
      conf_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      heat_q  <= heat_d;
      cool_q  <= cool_d;
      conf_q  <= conf_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.heating    = heat_q;
  assign bus.cooling    = cool_q;
  assign bus.zone_grant = grant_q;
  assign bus.conflict   = conf_q;
  assign bus.busy       = busy_q;
endmodule
